// File: rtl/jtkicker_obj_pkg.sv
// rtl/jtkicker_obj_pkg.sv - shared constants, state encodings and tile pixel unpack for the object engine
package jtkicker_obj_pkg;

    localparam logic [1:0] OFS_Y    = 2'd0;
    localparam logic [1:0] OFS_CODE = 2'd1;
    localparam logic [1:0] OFS_ATTR = 2'd2;
    localparam logic [1:0] OFS_X    = 2'd3;

    localparam logic [3:0] TRANSPARENT = 4'd0;

    typedef enum logic [2:0] {S_IDLE, S_Y, S_YCHK, S_CODE, S_ATTR, S_X} scan_st_t;
    typedef enum logic [1:0] {D_IDLE, D_FETCH, D_DRAW, D_FLUSH} draw_st_t;

    // Pixels 0..3 live in the upper half-word, 4..7 in the lower one; planes are interleaved per nibble
    function automatic logic [3:0] unpack_pxl(input logic [31:0] w, input logic [2:0] k);
        logic [15:0] h;
        logic [3:0]  j;
        h = k[2] ? w[15:0] : w[31:16];
        j = {2'd0, k[1:0]};
        return {h[4'd11 - j], h[4'd15 - j], h[4'd3 - j], h[4'd7 - j]};
    endfunction

endpackage

// File: rtl/jtframe_obj_buffer.sv
// rtl/jtframe_obj_buffer.sv - double line buffer with transparent-write skip and erase-after-read
module jtframe_obj_buffer #(
    parameter int AW    = 8,
    parameter int DW    = 4,
    parameter int ALPHA = 0
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          LHBL,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] wr_addr,
    input  logic          we,
    input  logic [AW-1:0] rd_addr,
    input  logic          rd,
    output logic [DW-1:0] rd_data
);
    logic          line;
    logic          lhbl_l;
    logic [DW-1:0] mem [0:2**(AW+1)-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            line   <= 1'b0;
            lhbl_l <= 1'b1;
        end else begin
            lhbl_l <= LHBL;
            if (lhbl_l && !LHBL) line <= ~line;
        end
    end

    // Drawing uses bank "line", the mixer reads and clears the other one
    always_ff @(posedge clk) begin
        if (we && wr_data != DW'(ALPHA)) mem[{line, wr_addr}] <= wr_data;
        if (rd) begin
            rd_data                <= mem[{~line, rd_addr}];
            mem[{~line, rd_addr}]  <= DW'(ALPHA);
        end
    end
endmodule

// File: rtl/jtkicker_objdraw.sv
// rtl/jtkicker_objdraw.sv - sprite drawer: ROM word fetch, pixel shift, palette PROM and buffer write
module jtkicker_objdraw import jtkicker_obj_pkg::*; #(
    parameter int VH    = 16,
    parameter int HW    = 2,
    parameter int CODEW = 8,
    parameter int PALW  = 4,
    parameter int RB    = $clog2(VH),
    parameter int CB    = $clog2(HW),
    parameter int AW    = CODEW + RB + CB
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             abort,
    input  logic             start,
    input  logic [CODEW-1:0] code,
    input  logic [PALW-1:0]  pal,
    input  logic             hflip,
    input  logic             vflip,
    input  logic [7:0]       xpos,
    input  logic [RB-1:0]    ydiff,
    input  logic             flip,
    output logic             busy,
    output logic [AW-1:0]    rom_addr,
    output logic             rom_cs,
    input  logic [31:0]      rom_data,
    input  logic             rom_ok,
    input  logic [PALW+3:0]  prog_addr,
    input  logic [3:0]       prog_data,
    input  logic             prog_en,
    output logic [7:0]       buf_addr,
    output logic [3:0]       buf_data,
    output logic             buf_we
);
    localparam int CBW = CB > 0 ? CB : 1;

    draw_st_t         st;
    logic [CODEW-1:0] code_l;
    logic [PALW-1:0]  pal_l;
    logic             hf_l;
    logic [RB-1:0]    row_l;
    logic [7:0]       pos;
    logic [CBW-1:0]   wcnt;
    logic [CBW-1:0]   col;
    logic [2:0]       k;
    logic [31:0]      word;
    logic [3:0]       prom [0:2**(PALW+4)-1];
    logic [3:0]       pal_dout;
    logic [7:0]       wr_addr;
    logic             wr_pend;
    logic             last_word;

    assign last_word = wcnt == CBW'(HW - 1);
    assign col       = hf_l ? CBW'(HW - 1) - wcnt : wcnt;
    assign rom_addr  = (AW'({code_l, row_l}) << CB) | AW'(col);
    assign busy      = st != D_IDLE;
    assign buf_addr  = wr_addr;
    assign buf_data  = pal_dout;
    assign buf_we    = wr_pend & ~abort;

    // Palette lookup runs every clock; only DRAW cycles are turned into writes
    always_ff @(posedge clk) begin
        if (prog_en) prom[prog_addr] <= prog_data;
        pal_dout <= prom[{pal_l, unpack_pxl(word, hf_l ? ~k : k)}];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st      <= D_IDLE;
            rom_cs  <= 1'b0;
            wr_pend <= 1'b0;
            wr_addr <= 8'd0;
            code_l  <= '0;
            pal_l   <= '0;
            hf_l    <= 1'b0;
            row_l   <= '0;
            pos     <= 8'd0;
            wcnt    <= '0;
            k       <= 3'd0;
            word    <= 32'd0;
        end else if (abort) begin
            st      <= D_IDLE;
            rom_cs  <= 1'b0;
            wr_pend <= 1'b0;
        end else begin
            wr_pend <= st == D_DRAW;
            wr_addr <= pos;
            case (st)
                D_IDLE: if (start) begin
                    code_l <= code;
                    pal_l  <= pal;
                    hf_l   <= hflip ^ flip;
                    row_l  <= ydiff ^ {RB{vflip}};
                    pos    <= flip ? 8'hFF - xpos - 8'(8 * HW - 1) : xpos;
                    wcnt   <= '0;
                    rom_cs <= 1'b1;
                    st     <= D_FETCH;
                end
                D_FETCH: if (rom_ok) begin
                    word   <= rom_data;
                    rom_cs <= 1'b0;
                    k      <= 3'd0;
                    st     <= D_DRAW;
                end
                D_DRAW: begin
                    k   <= k + 3'd1;
                    pos <= pos + 8'd1;
                    if (k == 3'd7) begin
                        if (last_word) begin
                            st <= D_FLUSH;
                        end else begin
                            wcnt   <= wcnt + CBW'(1);
                            rom_cs <= 1'b1;
                            st     <= D_FETCH;
                        end
                    end
                end
                default: st <= D_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/jtkicker_objgen.sv
// rtl/jtkicker_objgen.sv - line-based sprite engine: table scan FSM, drawer and double line buffer
module jtkicker_objgen import jtkicker_obj_pkg::*; #(
    parameter int OBJCNT  = 32,
    parameter int VH      = 16,
    parameter int HW      = 2,
    parameter int CODEW   = 8,
    parameter int PALW    = 4,
    parameter int MAXLINE = 8,
    parameter int SAW     = $clog2(OBJCNT) + 2,
    parameter int RB      = $clog2(VH),
    parameter int CB      = $clog2(HW),
    parameter int AW      = CODEW + RB + CB
)(
    input  logic            clk,
    input  logic            rst,
    input  logic            pxl_cen,
    input  logic            hinit,
    input  logic            LHBL,
    input  logic [7:0]      vrender,
    input  logic [8:0]      hdump,
    input  logic            flip,
    output logic [SAW-1:0]  scan_addr,
    input  logic [7:0]      scan_dout,
    input  logic [PALW+3:0] prog_addr,
    input  logic [3:0]      prog_data,
    input  logic            prog_en,
    output logic [AW-1:0]   rom_addr,
    input  logic [31:0]     rom_data,
    output logic            rom_cs,
    input  logic            rom_ok,
    output logic [3:0]      pxl,
    output logic            line_ovf
);
    localparam int IW = SAW - 2;
    localparam int CW = $clog2(MAXLINE + 1);

    scan_st_t         st, nx;
    logic [IW-1:0]    idx;
    logic [CW-1:0]    cnt;
    logic             ovf;
    logic [1:0]       sub;
    logic [7:0]       ydiff;
    logic             hit, last, start, busy;
    logic [CODEW-1:0] code_l;
    logic [PALW-1:0]  pal_l;
    logic             hf_l, vf_l;
    logic [RB-1:0]    ydiff_l;
    logic [7:0]       buf_addr;
    logic [3:0]       buf_data;
    logic             buf_we;
    logic             unused_hdump;

    assign unused_hdump = hdump[8];
    assign scan_addr    = {idx, sub};

    always_comb begin
        nx    = st;
        start = 1'b0;
        sub   = OFS_Y;
        ydiff = vrender - scan_dout;
        hit   = ydiff < 8'(VH);
        last  = idx == IW'(OBJCNT - 1);
        case (st)
            S_Y:    nx = S_YCHK;
            S_YCHK: begin
                sub = OFS_CODE;
                nx  = hit ? S_CODE : (last ? S_IDLE : S_Y);
            end
            S_CODE: begin sub = OFS_ATTR; nx = S_ATTR; end
            S_ATTR: begin sub = OFS_X;    nx = S_X;    end
            S_X: begin
                sub = OFS_X;
                if (!busy) begin
                    start = 1'b1;
                    nx    = (cnt == CW'(MAXLINE - 1) || last) ? S_IDLE : S_Y;
                end
            end
            default: nx = S_IDLE;
        endcase
        // A new line restarts the scan regardless of where the previous one got to
        if (hinit) begin
            nx    = S_Y;
            start = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st       <= S_IDLE;
            idx      <= '0;
            cnt      <= '0;
            ovf      <= 1'b0;
            line_ovf <= 1'b0;
            code_l   <= '0;
            pal_l    <= '0;
            hf_l     <= 1'b0;
            vf_l     <= 1'b0;
            ydiff_l  <= '0;
        end else begin
            st <= nx;
            if (hinit) begin
                idx      <= '0;
                cnt      <= '0;
                ovf      <= 1'b0;
                line_ovf <= ovf;
            end else begin
                case (st)
                    S_YCHK: begin
                        ydiff_l <= ydiff[RB-1:0];
                        if (!hit) idx <= idx + IW'(1);
                    end
                    S_CODE: code_l <= scan_dout[CODEW-1:0];
                    S_ATTR: begin
                        pal_l <= scan_dout[PALW-1:0];
                        hf_l  <= scan_dout[6];
                        vf_l  <= scan_dout[7];
                    end
                    S_X: if (start) begin
                        idx <= idx + IW'(1);
                        cnt <= cnt + CW'(1);
                        if (cnt == CW'(MAXLINE - 1)) ovf <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    jtkicker_objdraw #(
        .VH(VH), .HW(HW), .CODEW(CODEW), .PALW(PALW), .RB(RB), .CB(CB), .AW(AW)
    ) u_draw (
        .clk       (clk),
        .rst       (rst),
        .abort     (hinit),
        .start     (start),
        .code      (code_l),
        .pal       (pal_l),
        .hflip     (hf_l),
        .vflip     (vf_l),
        .xpos      (scan_dout),
        .ydiff     (ydiff_l),
        .flip      (flip),
        .busy      (busy),
        .rom_addr  (rom_addr),
        .rom_cs    (rom_cs),
        .rom_data  (rom_data),
        .rom_ok    (rom_ok),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .prog_en   (prog_en),
        .buf_addr  (buf_addr),
        .buf_data  (buf_data),
        .buf_we    (buf_we)
    );

    jtframe_obj_buffer #(.AW(8), .DW(4), .ALPHA(0)) u_buffer (
        .clk     (clk),
        .rst     (rst),
        .LHBL    (LHBL),
        .wr_data (buf_data),
        .wr_addr (buf_addr),
        .we      (buf_we),
        .rd_addr (hdump[7:0]),
        .rd      (pxl_cen),
        .rd_data (pxl)
    );
endmodule

// File: tb/tb_jtkicker_objgen.sv
// tb/tb_jtkicker_objgen.sv - scoreboard bench for jtkicker_objgen against a line-level reference model
module tb_jtkicker_objgen;
    localparam int OBJCNT = 32, VH = 16, HW = 2, CODEW = 8, PALW = 4, MAXLINE = 8;
    localparam int SAW = 7, AW = 13;

    logic             clk = 0, rst = 1, pxl_cen = 0, hinit = 0, LHBL = 1, flip = 0;
    logic [7:0]       vrender = 0, scan_dout = 0;
    logic [8:0]       hdump = 0;
    logic [SAW-1:0]   scan_addr;
    logic [PALW+3:0]  prog_addr = 0;
    logic [3:0]       prog_data = 0;
    logic             prog_en = 0;
    logic [AW-1:0]    rom_addr;
    logic [31:0]      rom_data = 0;
    logic             rom_cs, rom_ok = 0;
    logic [3:0]       pxl;
    logic             line_ovf;

    logic [7:0]    tbl [OBJCNT*4];
    logic [3:0]    pal_m [256];
    logic [3:0]    exp_line [256];
    logic [AW-1:0] exp_rom [$];
    logic [3:0]    exp_pxl [$];
    int  checks = 0, errors = 0;
    int  lat = 2, rom_cnt = 0;
    bit  chk_pxl = 0, exp_ovf = 0, prev_ovf = 0;

    jtkicker_objgen #(
        .OBJCNT(OBJCNT), .VH(VH), .HW(HW), .CODEW(CODEW), .PALW(PALW), .MAXLINE(MAXLINE)
    ) dut (
        .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .hinit(hinit), .LHBL(LHBL),
        .vrender(vrender), .hdump(hdump), .flip(flip),
        .scan_addr(scan_addr), .scan_dout(scan_dout),
        .prog_addr(prog_addr), .prog_data(prog_data), .prog_en(prog_en),
        .rom_addr(rom_addr), .rom_data(rom_data), .rom_cs(rom_cs), .rom_ok(rom_ok),
        .pxl(pxl), .line_ovf(line_ovf)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    function automatic logic [31:0] romf(input logic [AW-1:0] a);
        return (32'(a) * 32'h9E3779B1) ^ (32'(a) << 19) ^ 32'h3C5A_96E1;
    endfunction

    function automatic logic [3:0] pixel_of(input logic [31:0] w, input int k);
        int b, j;
        b = k < 4 ? 16 : 0;
        j = k % 4;
        return {w[b+11-j], w[b+15-j], w[b+3-j], w[b+7-j]};
    endfunction

    // Sprite table RAM: one clock of read latency
    initial begin : table_model
        logic [SAW-1:0] a;
        forever begin
            @(negedge clk); a = scan_addr;
            @(posedge clk); #1; scan_dout = tbl[a];
        end
    end

    // ROM: acknowledges after lat cycles of rom_cs; emits stray rom_ok pulses while idle
    initial begin : rom_model
        forever begin
            @(posedge clk); #1;
            if (rom_ok) begin
                rom_ok = 0;
            end else if (rom_cs) begin
                rom_cnt++;
                if (rom_cnt >= lat) begin
                    rom_cnt  = 0;
                    rom_ok   = 1;
                    rom_data = romf(rom_addr);
                    if (exp_rom.size() == 0) check("rom_unexpected_req", 1, 0);
                    else check("rom_addr", int'(rom_addr), int'(exp_rom.pop_front()));
                end
            end else begin
                rom_cnt = 0;
                if ($urandom_range(0, 7) == 0) begin
                    rom_ok   = 1;
                    rom_data = $urandom;
                end
            end
        end
    end

    initial begin : pxl_monitor
        bit cen_s;
        forever begin
            @(posedge clk); cen_s = pxl_cen;
            @(negedge clk);
            if (cen_s && chk_pxl) begin
                if (exp_pxl.size() == 0) check("pxl_unexpected", 1, 0);
                else check("pxl", int'(pxl), int'(exp_pxl.pop_front()));
            end
        end
    end

    task automatic draw_sprite(input int n, input int ydiff, input int nwords);
        int code, attr, x, row, hf, sx, col, addr, c;
        logic [31:0] w;
        code = int'(tbl[4*n+1]); attr = int'(tbl[4*n+2]); x = int'(tbl[4*n+3]);
        row  = ((attr >> 7) & 1) ? VH - 1 - ydiff : ydiff;
        hf   = ((attr >> 6) & 1) ^ int'(flip);
        sx   = flip ? (255 - x - (8*HW - 1)) & 255 : x;
        for (int wi = 0; wi < nwords; wi++) begin
            col  = hf ? HW - 1 - wi : wi;
            addr = (code * VH + row) * HW + col;
            exp_rom.push_back(AW'(addr));
            w = romf(AW'(addr));
            for (int i = 0; i < 8; i++) begin
                c = int'(pal_m[(attr % 16) * 16 + int'(pixel_of(w, hf ? 7 - i : i))]);
                if (c != 0) exp_line[(sx + wi*8 + i) % 256] = 4'(c);
            end
        end
    endtask

    task automatic model_line();
        int drawn, yd;
        drawn = 0;
        exp_ovf = 0;
        foreach (exp_line[i]) exp_line[i] = 0;
        for (int n = 0; n < OBJCNT; n++) begin
            yd = (int'(vrender) - int'(tbl[4*n])) & 255;
            if (yd < VH) begin
                draw_sprite(n, yd, HW);
                drawn++;
                if (drawn == MAXLINE) begin exp_ovf = 1; break; end
            end
        end
    endtask

    task automatic pulse_hinit();
        hinit = 1; tick(1); hinit = 0;
        check("line_ovf", int'(line_ovf), int'(prev_ovf));
        check("rom_cs_after_hinit", int'(rom_cs), 0);
        prev_ovf = exp_ovf;
    endtask

    task automatic read_line(input bit check_it);
        chk_pxl = check_it;
        LHBL = 0; tick(2); LHBL = 1; tick(1);
        for (int h = 0; h < 256; h++) begin
            hdump = 9'(h); pxl_cen = 1;
            if (check_it) exp_pxl.push_back(exp_line[h]);
            tick(1);
        end
        pxl_cen = 0; tick(2);
        if (check_it) check("pxl_queue_drained", exp_pxl.size(), 0);
        exp_pxl.delete();
        chk_pxl = 0;
    endtask

    task automatic run_line();
        model_line();
        pulse_hinit();
        tick(600);
        check("rom_reqs_done", exp_rom.size(), 0);
        exp_rom.delete();
        read_line(1);
    endtask

    task automatic clear_tbl();
        for (int n = 0; n < OBJCNT; n++) begin
            tbl[4*n]   = vrender + 8'h80;
            tbl[4*n+1] = 8'($urandom);
            tbl[4*n+2] = 8'($urandom);
            tbl[4*n+3] = 8'($urandom);
        end
    endtask

    task automatic set_spr(input int n, input int y, input int code, input int attr, input int x);
        tbl[4*n] = 8'(y); tbl[4*n+1] = 8'(code); tbl[4*n+2] = 8'(attr); tbl[4*n+3] = 8'(x);
    endtask

    task automatic wait_cs(input bit v, output bit ok);
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (rom_cs == v) ok = 1; else tick(1);
        end
    endtask

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin : stim
        bit ok;
        rst = 1; tick(5);
        check("reset_rom_cs", int'(rom_cs), 0);
        check("reset_rom_addr", int'(rom_addr), 0);
        check("reset_scan_addr", int'(scan_addr), 0);
        check("reset_line_ovf", int'(line_ovf), 0);
        rst = 0; tick(1);

        for (int a = 0; a < 256; a++) begin
            pal_m[a]  = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            prog_addr = 8'(a); prog_data = pal_m[a]; prog_en = 1;
            tick(1);
        end
        prog_en = 0;
        read_line(0);
        read_line(0);

        // Directed sprites
        vrender = 8'h25; flip = 0; lat = 2;
        clear_tbl(); set_spr(0, 8'h20, 8'h05, 8'h03, 8'h40); run_line();
        clear_tbl(); set_spr(0, 8'h20, 8'h05, 8'h83, 8'h40); run_line();
        clear_tbl(); set_spr(0, 8'h20, 8'h05, 8'h43, 8'h40); run_line();
        flip = 1;
        clear_tbl(); set_spr(0, 8'h20, 8'h05, 8'h03, 8'h40); run_line();
        flip = 0; vrender = 8'h03;
        clear_tbl(); set_spr(3, 8'hF8, 8'h05, 8'h03, 8'hF8); run_line();

        // Ten hits on one line, then two quiet lines for the overflow flag
        vrender = 8'h25; clear_tbl();
        for (int n = 0; n < 10; n++) set_spr(n, 8'h20, $urandom, $urandom, $urandom);
        run_line();
        clear_tbl(); run_line();
        clear_tbl(); run_line();

        // hinit during the second word fetch
        lat = 20; clear_tbl(); set_spr(0, 8'h20, 8'h11, 8'h05, 8'h60);
        foreach (exp_line[i]) exp_line[i] = 0;
        draw_sprite(0, 5, 1);
        exp_ovf = 0;
        pulse_hinit();
        wait_cs(1, ok); check("abort_wait_word0", int'(ok), 1);
        wait_cs(0, ok); check("abort_wait_gap", int'(ok), 1);
        wait_cs(1, ok); check("abort_wait_word1", int'(ok), 1);
        tick(3);
        tbl[0] = vrender + 8'h80;
        pulse_hinit();
        tick(300);
        check("abort_rom_reqs", exp_rom.size(), 0);
        exp_rom.delete();
        read_line(1);

        // Randomised lines
        for (int t = 0; t < 6; t++) begin
            vrender = 8'($urandom); flip = 1'($urandom); lat = $urandom_range(1, 4);
            for (int n = 0; n < OBJCNT; n++) begin
                tbl[4*n]   = ($urandom_range(0, 3) == 0) ? vrender - 8'($urandom_range(0, VH-1)) : 8'($urandom);
                tbl[4*n+1] = 8'($urandom);
                tbl[4*n+2] = 8'($urandom);
                tbl[4*n+3] = 8'($urandom);
            end
            run_line();
        end
        clear_tbl(); run_line();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
